// File: rtl/mode_counter.sv
// Multi-mode counter: up, down, reverse (bounce) and Johnson sequencing with load and terminal count.
// Define MODE_COUNTER_JOHNSON_EN to build Johnson mode; otherwise mode 3 aliases to up.
module mode_counter #(
    parameter  int MAX   = 16,
    localparam int WIDTH = $clog2(MAX)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    localparam logic [1:0] MODE_UP     = 2'd0;
    localparam logic [1:0] MODE_DOWN   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;

    localparam logic [WIDTH-1:0] TOP    = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] TOP_M1 = WIDTH'(MAX - 2);
    localparam logic [WIDTH-1:0] ZERO   = '0;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic             is_johnson;
    logic             over_range;
    logic [WIDTH-1:0] count_step;
    logic             dir_step;
    logic [WIDTH-1:0] load_eff;

`ifdef MODE_COUNTER_JOHNSON_EN
    localparam logic [WIDTH-1:0] JOHNSON_TC = ONE << (WIDTH - 1);
    logic [WIDTH-1:0] johnson_next;

    // Shift left, feeding back the inverted MSB; the cast drops the old MSB.
    assign johnson_next = WIDTH'({count, ~count[WIDTH-1]});
    assign is_johnson   = (mode == 2'd3);
`else
    assign is_johnson   = 1'b0;
`endif

    // Counts above MAX-1 can only appear after Johnson mode or a Johnson load.
    assign over_range = (count > TOP);
    assign load_eff   = (!is_johnson && (load_value > TOP)) ? TOP : load_value;

    always_comb begin
        count_step = count;
        dir_step   = dir;
        if (is_johnson) begin
`ifdef MODE_COUNTER_JOHNSON_EN
            count_step = johnson_next;
`endif
        end else begin
            case (mode)
                MODE_DOWN: begin
                    if (over_range || count == ZERO) count_step = TOP;
                    else                             count_step = count - ONE;
                end
                MODE_BOUNCE: begin
                    if (over_range) begin
                        count_step = TOP;
                    end else if (dir) begin
                        if (count == TOP) begin
                            count_step = TOP_M1;
                            dir_step   = 1'b0;
                        end else begin
                            count_step = count + ONE;
                        end
                    end else begin
                        if (count == ZERO) begin
                            count_step = ONE;
                            dir_step   = 1'b1;
                        end else begin
                            count_step = count - ONE;
                        end
                    end
                end
                default: begin
                    if (count >= TOP) count_step = ZERO;
                    else              count_step = count + ONE;
                end
            endcase
        end
    end

    always_comb begin
        tc = 1'b0;
        if (is_johnson) begin
`ifdef MODE_COUNTER_JOHNSON_EN
            tc = (count == JOHNSON_TC);
`endif
        end else begin
            case (mode)
                MODE_DOWN:   tc = (count == ZERO);
                MODE_BOUNCE: tc = (dir && count == TOP) || (!dir && count == ZERO);
                default:     tc = (count == TOP);
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= ZERO;
            dir   <= 1'b1;
        end else if (load) begin
            count <= load_eff;
        end else if (enable) begin
            count <= count_step;
            dir   <= dir_step;
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter: a MAX=16 and a MAX=10 instance share clock and controls.
// Johnson-mode checks follow MODE_COUNTER_JOHNSON_EN; without it mode 3 is checked as up mode.
module tb_mode_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       load = 1'b0;
    logic [3:0] lv16 = 4'd0;
    logic [3:0] lv10 = 4'd0;
    logic [3:0] c16, c10;
    logic       d16, d10, t16, t10;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mode_counter #(.MAX(16)) u_dut16 (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .load(load),
        .load_value(lv16), .count(c16), .dir(d16), .tc(t16)
    );

    mode_counter #(.MAX(10)) u_dut10 (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .load(load),
        .load_value(lv10), .count(c10), .dir(d10), .tc(t10)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_c, exp_d;
        int jseq [9] = '{0, 1, 3, 7, 15, 14, 12, 8, 0};

        // Reset state and tc after reset in each binary mode
        load = 1'b1; enable = 1'b1; lv16 = 4'd9; lv10 = 4'd7;
        do_reset();
        load = 1'b0; enable = 1'b0;
        check("rst_count16", c16, 0);
        check("rst_dir16", d16, 1);
        check("rst_count10", c10, 0);
        check("rst_dir10", d10, 1);
        check("rst_tc_up", t16, 0);
        mode = 2'd1; #1;
        check("rst_tc_down", t16, 1);
        mode = 2'd2; #1;
        check("rst_tc_bounce", t16, 0);

        // Up mode, MAX=16, 20 values
        mode = 2'd0; enable = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            check("up_count", c16, i % 16);
            check("up_tc", t16, (i % 16 == 15) ? 1 : 0);
            tick();
        end

        // Down mode, MAX=16
        mode = 2'd1;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            exp_c = (16 - (i % 16)) % 16;
            check("down_count", c16, exp_c);
            check("down_tc", t16, (exp_c == 0) ? 1 : 0);
            tick();
        end

        // Reverse mode, MAX=10: 0..9, 8..0, 1
        mode = 2'd2;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i <= 9)       begin exp_c = i;      exp_d = 1; end
            else if (i <= 18) begin exp_c = 18 - i; exp_d = 0; end
            else              begin exp_c = 1;      exp_d = 1; end
            check("bounce_count", c10, exp_c);
            check("bounce_dir", d10, exp_d);
            check("bounce_tc", t10, (i == 9 || i == 18) ? 1 : 0);
            tick();
        end

        // Mode 3 on the MAX=16 instance
        mode = 2'd3;
        do_reset();
        for (int i = 0; i < 9; i++) begin
`ifdef MODE_COUNTER_JOHNSON_EN
            check("johnson_count", c16, jseq[i]);
            check("johnson_tc", t16, (jseq[i] == 8) ? 1 : 0);
`else
            check("mode3_up_count", c16, i);
            check("mode3_up_tc", t16, 0);
`endif
            tick();
        end

        // Load in mode 3 on MAX=10 with an out-of-range value
        enable = 1'b0; load = 1'b1; lv10 = 4'd12;
        tick();
        load = 1'b0;
`ifdef MODE_COUNTER_JOHNSON_EN
        check("jload_raw", c10, 12);
        mode = 2'd1; #1;
        check("over_tc_down", t10, 0);
        enable = 1'b1;
        tick();
        check("over_down_next", c10, 9);
        mode = 2'd3; enable = 1'b0; load = 1'b1;
        tick();
        load = 1'b0; mode = 2'd0; enable = 1'b1; #1;
        check("over_tc_up", t10, 0);
        tick();
        check("over_up_next", c10, 0);
`else
        check("mode3_load_sat", c10, 9);
        check("mode3_load_tc", t10, 1);
`endif

        // Load saturation, load beats enable, then load with reset
        mode = 2'd0; enable = 1'b1; load = 1'b1; lv10 = 4'd12; lv16 = 4'd5;
        tick();
        check("load_sat10", c10, 9);
        check("load_sat_tc10", t10, 1);
        check("load16", c16, 5);
        load = 1'b0;
        tick();
        check("load_wrap10", c10, 0);
        check("load_step16", c16, 6);
        reset = 1'b1; load = 1'b1;
        tick();
        reset = 1'b0; load = 1'b0;
        check("load_rst10", c10, 0);
        check("load_rst16", c16, 0);

        // Mode changes take effect on the next enabled step
        tick(); tick(); tick();
        check("mchg_up", c16, 3);
        mode = 2'd1;
        tick();
        check("mchg_down", c16, 2);
        mode = 2'd2;
        tick();
        check("mchg_bounce", c16, 3);

        // Reverse mode, MAX=10: count 5 with dir 0, hold, load, reset
        mode = 2'd2; enable = 1'b1;
        do_reset();
        repeat (13) tick();
        check("mid_count", c10, 5);
        check("mid_dir", d10, 0);
        enable = 1'b0;
        repeat (3) tick();
        check("hold_count", c10, 5);
        check("hold_dir", d10, 0);
        load = 1'b1; lv10 = 4'd7;
        tick();
        load = 1'b0;
        check("load_keep_dir", d10, 0);
        check("load_bounce", c10, 7);
        enable = 1'b1;
        tick();
        check("after_load_step", c10, 6);
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b0;
        check("midrst_count", c10, 0);
        check("midrst_dir", d10, 1);
        repeat (3) tick();
        check("rst_hold_count", c10, 0);
        check("rst_hold_dir", d10, 1);
        check("rst_hold_tc", t10, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
- REQ-001: Parameter MAX, default 16: counter modulus; binary count range is 0..MAX-1; MAX >= 2.
- REQ-002: Local parameter WIDTH = $clog2(MAX): count width, 4 at the default.
- REQ-003: Port clock, input, 1 bit: single clock; all state changes on the rising edge.
- REQ-004: Port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005: Port enable, input, 1 bit: advances the count one step per clock while high.
- REQ-006: Port mode, input, 2 bits: 0 = up, 1 = down, 2 = reverse (bounce), 3 = Johnson.
- REQ-007: Port load, input, 1 bit: synchronous load of load_value.
- REQ-008: Port load_value, input, WIDTH bits: value captured on load.
- REQ-009: Port count, output, WIDTH bits: registered counter state.
- REQ-010: Port dir, output, 1 bit: registered bounce direction, 1 = up, 0 = down.
- REQ-011: Port tc, output, 1 bit: combinational terminal-count flag.

Function
- REQ-012: Priority is reset > load > enable; with none active, count and dir hold.
- REQ-013: Up mode: count increments; at MAX-1 the next value is 0.
- REQ-014: Down mode: count decrements; at 0 the next value is MAX-1.
- REQ-015: Reverse mode: count steps in the direction given by dir; end values are visited once per sweep (0,1..MAX-1,MAX-2..0,1...).
- REQ-016: Reverse mode: on an enabled step from MAX-1 with dir=1, count becomes MAX-2 and dir becomes 0; from 0 with dir=0, count becomes 1 and dir becomes 1.
- REQ-017: Johnson mode: next count = {count[WIDTH-2:0], ~count[WIDTH-1]}, a 2*WIDTH-state cycle starting at 0.
- REQ-018: dir changes only in reverse mode; other modes hold dir.
- REQ-019: tc = 1 when count is the terminal value for the current mode: up = MAX-1; down = 0; reverse = MAX-1 with dir=1, or 0 with dir=0; Johnson = 1 followed by WIDTH-1 zeros.
- REQ-020: tc does not depend on enable.
- REQ-021: tc = 0 when count >= MAX in a binary mode.
- REQ-022: Mode changes take effect at the next enabled step, starting from the current count; latency is zero extra cycles.
- REQ-023: Binary mode with count > MAX-1 (left over from Johnson mode): next enabled value is 0 in up mode and MAX-1 in down or reverse mode.
- REQ-024: Load in a binary mode: load_value > MAX-1 saturates to MAX-1.
- REQ-025: Load in Johnson mode: load_value is taken unmodified.
- REQ-026: Load leaves dir unchanged.
- REQ-027: Load and enable in the same cycle: load wins, with no additional step.

Reset
- REQ-028: On reset, count = 0 and dir = 1 at the next rising edge, regardless of load, enable or mode.
- REQ-029: Reset mid-sweep or mid-Johnson-cycle is honoured the same cycle.
- REQ-030: After reset, tc = 1 only in down mode, or in reverse mode after dir returns to 0.

Configuration
- REQ-031: Macro MODE_COUNTER_JOHNSON_EN defined: Johnson mode (mode=3) is built per REQ-017, REQ-019 and REQ-025.
- REQ-032: Macro MODE_COUNTER_JOHNSON_EN undefined: no Johnson logic is built; mode=3 behaves identically to mode=0 (up), including tc and load saturation.

Verification
- REQ-033: MAX=16, mode=0, enable=1, 20 clocks after reset -> count 0..15,0..3; tc high only while count=15.
- REQ-034: MAX=16, mode=1, enable=1 after reset -> count 0,15,14,..,0,15; tc high only while count=0.
- REQ-035: MAX=10, mode=2, enable=1 after reset -> count 0..9,8..0,1; dir goes to 0 on the edge leaving 9 and to 1 on the edge leaving 0.
- REQ-036: MAX=16, Johnson macro defined, mode=3 -> count 0000,0001,0011,0111,1111,1110,1100,1000,0000; tc high only at 1000.
- REQ-037: MAX=10, mode=0: load=1, enable=1, load_value=12 -> count=9, tc=1; next enabled step -> 0; load and reset together -> count=0.
- REQ-038: MAX=10, mode=2, reset pulsed at count=5 with dir=0 -> next edge count=0, dir=1; enable low for 3 cycles -> count and dir hold.
